// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register with a skid buffer, synchronous flush and a
// saturating stall-cycle counter. readyOut comes from registered state only.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              flush,
    input  logic              clrStat,
    input  logic              validIn,
    output logic              readyOut,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [CTRL_W-1:0] ctrlIn,
    output logic              validOut,
    input  logic              readyIn,
    output logic [DATA_W-1:0] dataOut,
    output logic [CTRL_W-1:0] ctrlOut,
    output logic [CNT_W-1:0]  stallCnt
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        state, stateNext;
    logic [DATA_W-1:0] mainData, skidData;
    logic [CTRL_W-1:0] mainCtrl, skidCtrl;
    logic              accept, emit;
    logic              loadMainIn, loadMainSkid, loadSkid;

    assign readyOut = (state != FULL);
    assign validOut = (state != EMPTY);
    assign accept   = validIn && readyOut;
    assign emit     = validOut && readyIn;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (which would infer a latch).
        stateNext    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    stateNext  = ONE;
                    loadMainIn = 1'b1;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    loadMainIn = 1'b1;
                end else if (accept) begin
                    stateNext = FULL;
                    loadSkid  = 1'b1;
                end else if (emit) begin
                    stateNext = EMPTY;
                end
            end
            FULL: begin
                if (emit) begin
                    stateNext    = ONE;
                    loadMainSkid = 1'b1;
                end
            end
            default: stateNext = EMPTY;
        endcase
        // Flush wins over everything, including a same-cycle accept.
        if (flush) begin
            stateNext    = EMPTY;
            loadMainIn   = 1'b0;
            loadMainSkid = 1'b0;
            loadSkid     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: payload registers are reset only because dataOut must read zero during reset; otherwise they would not need it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mainData <= '0;
            mainCtrl <= '0;
            skidData <= '0;
            skidCtrl <= '0;
        end else begin
            if (loadMainIn) begin
                mainData <= dataIn;
                mainCtrl <= ctrlIn;
            end else if (loadMainSkid) begin
                mainData <= skidData;
                mainCtrl <= skidCtrl;
            end
            if (loadSkid) begin
                skidData <= dataIn;
                skidCtrl <= ctrlIn;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stallCnt <= '0;
        end else if (clrStat) begin
            stallCnt <= '0;
        end else if (validOut && !readyIn && (stallCnt != '1)) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    assign dataOut = mainData;
    assign ctrlOut = validOut ? mainCtrl : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic, with a
// scoreboard queue filled on accept and drained on emit.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } entry_t;

    logic              clk = 1'b0;
    logic              resetN = 1'b1;
    logic              flush = 1'b0;
    logic              clrStat = 1'b0;
    logic              validIn = 1'b0;
    logic              readyOut;
    logic [DATA_W-1:0] dataIn = '0;
    logic [CTRL_W-1:0] ctrlIn = '0;
    logic              validOut;
    logic              readyIn = 1'b0;
    logic [DATA_W-1:0] dataOut;
    logic [CTRL_W-1:0] ctrlOut;
    logic [CNT_W-1:0]  stallCnt;

    entry_t           sb[$];
    logic [CNT_W-1:0] modelStall = '0;
    int               nChecks = 0;
    int               nPass = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetN(resetN), .flush(flush), .clrStat(clrStat),
        .validIn(validIn), .readyOut(readyOut), .dataIn(dataIn), .ctrlIn(ctrlIn),
        .validOut(validOut), .readyIn(readyIn), .dataOut(dataOut),
        .ctrlOut(ctrlOut), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [CTRL_W-1:0] ctrlFor(input logic [DATA_W-1:0] d);
        return d[CTRL_W-1:0] | 8'h01;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r);
        validIn = v;
        dataIn  = d;
        ctrlIn  = ctrlFor(d);
        readyIn = r;
    endtask

    // Scoreboard monitor: samples on the falling edge, predicts the next rising edge.
    always @(negedge clk) begin
        if (resetN) begin
            bit expValid;
            bit expReady;
            entry_t e;
            expValid = (sb.size() != 0);
            expReady = (sb.size() < 2);
            check("validOut", 64'(validOut), 64'(expValid));
            check("readyOut", 64'(readyOut), 64'(expReady));
            check("stallCnt", 64'(stallCnt), 64'(modelStall));
            if (!validOut) check("ctrlIdle", 64'(ctrlOut), 64'd0);
            if (flush) begin
                sb.delete();
            end else begin
                if (expValid && readyIn) begin
                    e = sb.pop_front();
                    check("dataOut", 64'(dataOut), 64'(e.d));
                    check("ctrlOut", 64'(ctrlOut), 64'(e.c));
                end
                if (validIn && expReady) begin
                    e.d = dataIn;
                    e.c = ctrlIn;
                    sb.push_back(e);
                end
            end
            if (clrStat) modelStall = '0;
            else if (expValid && !readyIn && modelStall != '1) modelStall = modelStall + 1'b1;
        end
    end

    initial begin
        // Reset state
        #1 resetN = 1'b0;
        #1;
        check("rstValid", 64'(validOut), 64'd0);
        check("rstReady", 64'(readyOut), 64'd1);
        check("rstData", 64'(dataOut), 64'd0);
        check("rstCtrl", 64'(ctrlOut), 64'd0);
        check("rstStall", 64'(stallCnt), 64'd0);
        step();
        step();
        resetN = 1'b1;
        step();

        // Pass-through, one per cycle
        drive(1'b1, 32'h11, 1'b1);
        step();
        check("pt0Valid", 64'(validOut), 64'd1);
        check("pt0Data", 64'(dataOut), 64'h11);
        drive(1'b1, 32'h22, 1'b1);
        step();
        check("pt1Data", 64'(dataOut), 64'h22);
        drive(1'b1, 32'h33, 1'b1);
        step();
        check("pt2Data", 64'(dataOut), 64'h33);
        check("pt2Valid", 64'(validOut), 64'd1);
        drive(1'b0, 32'h0, 1'b1);
        step();
        check("ptEmpty", 64'(validOut), 64'd0);

        // Backpressure into the skid buffer
        drive(1'b1, 32'hA, 1'b0);
        step();
        drive(1'b1, 32'hB, 1'b0);
        step();
        check("bpFullReady", 64'(readyOut), 64'd0);
        check("bpFullData", 64'(dataOut), 64'hA);
        drive(1'b1, 32'hC, 1'b0);
        step();
        step();
        check("bpHoldData", 64'(dataOut), 64'hA);
        readyIn = 1'b1;
        step();
        check("bpSkidData", 64'(dataOut), 64'hB);
        check("bpSkidReady", 64'(readyOut), 64'd1);
        step();
        check("bpThirdData", 64'(dataOut), 64'hC);
        drive(1'b0, 32'h0, 1'b1);
        step();
        check("bpDrained", 64'(validOut), 64'd0);

        // Flush while full with a same-cycle accept
        drive(1'b1, 32'hA, 1'b0);
        step();
        drive(1'b1, 32'hB, 1'b0);
        step();
        drive(1'b1, 32'hC, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flValid", 64'(validOut), 64'd0);
        check("flCtrl", 64'(ctrlOut), 64'd0);
        check("flReady", 64'(readyOut), 64'd1);
        drive(1'b0, 32'h0, 1'b1);
        repeat (3) step();

        // Stall counter saturation and clear
        clrStat = 1'b1;
        step();
        clrStat = 1'b0;
        drive(1'b1, 32'hD, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        repeat (20) step();
        check("stallSat", 64'(stallCnt), 64'd15);
        clrStat = 1'b1;
        step();
        clrStat = 1'b0;
        check("stallClr", 64'(stallCnt), 64'd0);
        readyIn = 1'b1;
        step();
        step();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0));
            step();
        end
        drive(1'b0, 32'h0, 1'b1);
        repeat (4) step();
        check("rndDrain", 64'(sb.size()), 64'd0);

        // Asynchronous reset between edges while full
        drive(1'b1, 32'h55, 1'b0);
        step();
        drive(1'b1, 32'h66, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        check("arFull", 64'(readyOut), 64'd0);
        #1 resetN = 1'b0;
        #1;
        check("arValid", 64'(validOut), 64'd0);
        check("arReady", 64'(readyOut), 64'd1);
        check("arStall", 64'(stallCnt), 64'd0);
        check("arData", 64'(dataOut), 64'd0);
        sb.delete();
        modelStall = '0;
        #1 resetN = 1'b1;
        step();
        drive(1'b1, 32'h77, 1'b1);
        step();
        check("arFirstValid", 64'(validOut), 64'd1);
        check("arFirstData", 64'(dataOut), 64'h77);
        drive(1'b0, 32'h0, 1'b1);
        step();
        step();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: DATA_W, default 32, datapath payload width (operands, immediates, PC+4 packed by instantiator).
REQ-002 Parameter: CTRL_W, default 8, control-bit payload width; all-zero control SHALL encode a bubble (NOP).
REQ-003 Parameter: CNT_W, default 16, width of the stall-cycle statistics counter.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: resetN  input  1  reset, asynchronous, active-low.
REQ-006 Port: flush  input  1  synchronous kill of all held entries.
REQ-007 Port: clrStat  input  1  synchronous clear of stallCnt.
REQ-008 Port: validIn  input  1  upstream entry present.
REQ-009 Port: readyOut  output  1  stage can accept an entry this cycle.
REQ-010 Port: dataIn  input  DATA_W  upstream data payload.
REQ-011 Port: ctrlIn  input  CTRL_W  upstream control payload.
REQ-012 Port: validOut  output  1  entry presented downstream.
REQ-013 Port: readyIn  input  1  downstream accepts this cycle (replaces the old stall input, readyIn = !stall).
REQ-014 Port: dataOut  output  DATA_W  presented data payload.
REQ-015 Port: ctrlOut  output  CTRL_W  presented control payload.
REQ-016 Port: stallCnt  output  CNT_W  cycles with validOut=1 and readyIn=0.

Function
REQ-017 Storage SHALL be two entries: main (drives outputs) and skid; state SHALL be EMPTY (none valid), ONE (main valid), FULL (main+skid valid).
REQ-018 readyOut SHALL equal NOT skid-valid, derived from registered state only (no combinational path from readyIn).
REQ-019 Accept = validIn AND readyOut; emit = validOut AND readyIn; validOut SHALL equal main-valid.
REQ-020 EMPTY: accept -> ONE, main loaded; no accept -> EMPTY.
REQ-021 ONE: accept AND emit -> ONE, main reloaded; accept only -> FULL, skid loaded; emit only -> EMPTY; neither -> hold.
REQ-022 FULL: emit -> ONE, skid moved to main; no emit -> hold both entries unchanged.
REQ-023 Order SHALL be strictly preserved; no entry dropped or duplicated except by flush.
REQ-024 Latency: accepted entry SHALL appear on validOut the next cycle when stage was EMPTY or emitted in the same cycle.
REQ-025 Full throughput: continuous validIn with readyIn=1 SHALL pass one entry per cycle.
REQ-026 ctrlOut SHALL be all-zero whenever validOut=0; dataOut SHALL hold its last value when invalid.
REQ-027 flush=1 SHALL move state to EMPTY next edge, discarding main, skid and any same-cycle accept; flush beats all other events.
REQ-028 stallCnt SHALL increment by 1 on each cycle with validOut=1 AND readyIn=0, saturating at 2^CNT_W-1 (no wrap).
REQ-029 clrStat SHALL zero stallCnt next edge, overriding a same-cycle increment; flush SHALL NOT affect stallCnt.

Reset
REQ-030 resetN=0 SHALL immediately force state EMPTY, validOut=0, readyOut=1, dataOut=0, ctrlOut=0, stallCnt=0, independent of clk.
REQ-031 Reset asserted mid-transfer SHALL discard both entries; first accept after release behaves as from EMPTY.

Verification
REQ-032 Pass-through: readyIn=1, entries 0x11,0x22,0x33 on consecutive cycles -> dataOut 0x11,0x22,0x33 on the following three cycles, validOut=1 throughout.
REQ-033 Backpressure: readyIn=0 while sending 0xA then 0xB -> FULL, readyOut=0; third entry 0xC held upstream; readyIn=1 -> outputs 0xA,0xB,0xC in order.
REQ-034 Flush: FULL with 0xA,0xB plus validIn=1 data 0xC, flush=1 -> next cycle validOut=0, ctrlOut=0, readyOut=1; 0xC never emitted.
REQ-035 Statistics: CNT_W=4, validOut=1, readyIn=0 for 20 cycles -> stallCnt saturates at 15; clrStat=1 -> 0 next cycle.
REQ-036 Async reset: resetN pulsed low between clock edges while FULL -> validOut=0, readyOut=1, stallCnt=0 before next edge.
